// File: rtl/tx_arbiter_if.sv
// Signals around the UART TX arbiter: producer strobes and data, UART busy,
// the UART parallel load port, and the overflow/error status flags.
interface tx_arbiter_if #(
    parameter int rd        = 8,
    parameter int ALU       = 8,
    parameter int UART_size = 8
);
    logic [rd-1:0]        rd_data;
    logic                 rdData_valid;
    logic [2*ALU-1:0]     ALU_OUT;
    logic                 out_valid;
    logic                 busy;
    logic [UART_size-1:0] TX_P_DATA;
    logic                 TX_D_VLD;
    logic                 ovf;
    logic                 tx_err;

    modport master (
        output rd_data, rdData_valid, ALU_OUT, out_valid, busy,
        input  TX_P_DATA, TX_D_VLD, ovf, tx_err
    );

    modport slave (
        input  rd_data, rdData_valid, ALU_OUT, out_valid, busy,
        output TX_P_DATA, TX_D_VLD, ovf, tx_err
    );
endinterface

// File: rtl/tx_arbiter.sv
// Round-robin sharing of one UART transmitter between register-read results
// (one byte) and ALU results (two bytes, LS first), each with a one-entry buffer.
module tx_arbiter #(
    parameter int rd        = 8,
    parameter int ALU       = 8,
    parameter int UART_size = 8,
    parameter int BUSY_TO   = 16
) (
    input  logic        clk,
    input  logic        rst,
    tx_arbiter_if.slave tx
);
    localparam int CNT_W = $clog2(BUSY_TO + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_e;

    typedef enum logic {
        SRC_RD  = 1'b0,
        SRC_ALU = 1'b1
    } src_e;

    state_e               state_r;
    src_e                 grant_r;
    src_e                 last_grant_r;
    src_e                 pick_s;
    logic                 byte_sel_r;
    logic [CNT_W-1:0]     to_cnt_r;
    logic [UART_size-1:0] tx_data_r;
    logic                 tx_vld_r;
    logic                 ovf_r;
    logic                 tx_err_r;

    logic [rd-1:0]        rd_buf_r;
    logic                 rd_pend_r;
    logic [2*ALU-1:0]     alu_buf_r;
    logic                 alu_pend_r;

    logic                 last_byte_s;
    logic                 rd_free_s;
    logic                 alu_free_s;
    logic                 rd_take_s;
    logic                 alu_take_s;
    logic                 drop_s;
    logic                 more_s;
    logic                 tie_s;

    // Buffer-free, capture/drop and arbitration decisions for the current cycle
    always_comb begin
        last_byte_s = tx_vld_r && ((grant_r == SRC_RD) || byte_sel_r);
        rd_free_s   = !rd_pend_r  || (last_byte_s && (grant_r == SRC_RD));
        alu_free_s  = !alu_pend_r || (last_byte_s && (grant_r == SRC_ALU));
        rd_take_s   = tx.rdData_valid && rd_free_s;
        alu_take_s  = tx.out_valid && alu_free_s;
        drop_s      = (tx.rdData_valid && !rd_free_s) || (tx.out_valid && !alu_free_s);
        more_s      = (grant_r == SRC_ALU) && !byte_sel_r;
        tie_s       = rd_pend_r && alu_pend_r;
        if (tie_s) begin
            pick_s = (last_grant_r == SRC_RD) ? SRC_ALU : SRC_RD;
        end else if (alu_pend_r) begin
            pick_s = SRC_ALU;
        end else begin
            pick_s = SRC_RD;
        end
    end

    // Holding buffers; a buffer frees in the load-strobe cycle of its last byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_buf_r   <= {rd{1'b0}};
            rd_pend_r  <= 1'b0;
            alu_buf_r  <= {(2*ALU){1'b0}};
            alu_pend_r <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            if (rd_take_s) begin
                rd_buf_r  <= tx.rd_data;
                rd_pend_r <= 1'b1;
            end else if (last_byte_s && (grant_r == SRC_RD)) begin
                rd_pend_r <= 1'b0;
            end else begin
                rd_pend_r <= rd_pend_r;
            end
            if (alu_take_s) begin
                alu_buf_r  <= tx.ALU_OUT;
                alu_pend_r <= 1'b1;
            end else if (last_byte_s && (grant_r == SRC_ALU)) begin
                alu_pend_r <= 1'b0;
            end else begin
                alu_pend_r <= alu_pend_r;
            end
            ovf_r <= drop_s;
        end
    end

    // Transfer sequencer with registered UART load port and error flag.
    // last_grant moves only when a real tie is resolved, so a lone request
    // does not steal the next tie from the other source.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= IDLE;
            grant_r      <= SRC_RD;
            last_grant_r <= SRC_ALU;
            byte_sel_r   <= 1'b0;
            to_cnt_r     <= {CNT_W{1'b0}};
            tx_data_r    <= {UART_size{1'b0}};
            tx_vld_r     <= 1'b0;
            tx_err_r     <= 1'b0;
        end else begin
            tx_vld_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!tx.busy && (rd_pend_r || alu_pend_r)) begin
                        grant_r <= pick_s;
                        if (tie_s) begin
                            last_grant_r <= pick_s;
                        end
                        tx_data_r  <= (pick_s == SRC_RD) ? rd_buf_r : alu_buf_r[ALU-1:0];
                        byte_sel_r <= 1'b0;
                        state_r    <= SEND;
                    end
                end
                SEND: begin
                    tx_vld_r <= 1'b1;
                    to_cnt_r <= {CNT_W{1'b0}};
                    state_r  <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx.busy) begin
                        state_r <= WAIT_LO;
                    end else if (to_cnt_r == CNT_W'(BUSY_TO - 1)) begin
                        // UART never acknowledged: flag it and carry on as if sent
                        tx_err_r <= 1'b1;
                        if (more_s) begin
                            tx_data_r  <= alu_buf_r[2*ALU-1:ALU];
                            byte_sel_r <= 1'b1;
                            state_r    <= SEND;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        to_cnt_r <= to_cnt_r + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!tx.busy) begin
                        if (more_s) begin
                            tx_data_r  <= alu_buf_r[2*ALU-1:ALU];
                            byte_sel_r <= 1'b1;
                            state_r    <= SEND;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign tx.TX_P_DATA = tx_data_r;
    assign tx.TX_D_VLD  = tx_vld_r;
    assign tx.ovf       = ovf_r;
    assign tx.tx_err    = tx_err_r;
endmodule
